// File: rtl/bus_master_pkg.sv
// Shared protocol definitions for the accelerator master bus: opcodes, field positions,
// transmitter state encoding and the latched job descriptor.
package bus_master_pkg;

  localparam logic [4:0] OP_NOOP         = 5'h00;
  localparam logic [4:0] OP_START_IMAGE  = 5'h01;
  localparam logic [4:0] OP_START_FILTER = 5'h02;
  localparam logic [4:0] OP_SET_OUTPUT   = 5'h03;
  localparam logic [4:0] OP_FILTER_INFO  = 5'h04;
  localparam logic [4:0] OP_FILTER_BIAS  = 5'h05;
  localparam logic [4:0] OP_IMAGE_INFO   = 5'h06;
  localparam logic [4:0] OP_DATA         = 5'h07;
  localparam logic [4:0] OP_RUN_ACCEL    = 5'h08;
`ifdef BUS_MASTER_PREAMBLE_RST_EN
  localparam logic [4:0] OP_PROTOCOL_RST = 5'h1F;
`endif

  localparam int META_HI = 22;
  localparam int META_LO = 18;
  localparam int DATA_HI = 17;
  localparam int DATA_LO = 0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_IMG_START = 4'd1,
    ST_IMG_INFO  = 4'd2,
    ST_IMG_DATA  = 4'd3,
    ST_FLT_START = 4'd4,
    ST_FLT_INFO  = 4'd5,
    ST_FLT_BIAS  = 4'd6,
    ST_FLT_DATA  = 4'd7,
    ST_SET_OUT   = 4'd8,
    ST_RUN       = 4'd9
`ifdef BUS_MASTER_PREAMBLE_RST_EN
    , ST_PRE_RST = 4'd10
`endif
  } state_t;

  typedef struct packed {
    logic [15:0] image_offset;
    logic [7:0]  image_dim;
    logic [8:0]  image_depth;
    logic [15:0] image_words;
    logic [15:0] filter_offset;
    logic [1:0]  filter_halfsize;
    logic [2:0]  filter_stride;
    logic [12:0] filter_length;
    logic [17:0] filter_bias;
    logic [15:0] output_offset;
  } job_desc_t;

endpackage

// File: rtl/bus_master_if.sv
// Host-side job/data handshake and accelerator bus output of the bus master.
// The master modport is the transmitter's view; slave is the host/DMA view.
interface bus_master_if;

  logic        job_valid;
  logic        job_ready;
  logic [15:0] image_offset;
  logic [7:0]  image_dim;
  logic [8:0]  image_depth;
  logic [15:0] image_words;
  logic [15:0] filter_offset;
  logic [1:0]  filter_halfsize;
  logic [2:0]  filter_stride;
  logic [12:0] filter_length;
  logic [17:0] filter_bias;
  logic [15:0] output_offset;
  logic [17:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [23:0] master_bus;
  logic        busy;
  logic        done;

  modport master (
    input  job_valid, image_offset, image_dim, image_depth, image_words,
           filter_offset, filter_halfsize, filter_stride, filter_length,
           filter_bias, output_offset, data_in, data_valid,
    output job_ready, data_ready, master_bus, busy, done
  );

  modport slave (
    output job_valid, image_offset, image_dim, image_depth, image_words,
           filter_offset, filter_halfsize, filter_stride, filter_length,
           filter_bias, output_offset, data_in, data_valid,
    input  job_ready, data_ready, master_bus, busy, done
  );

endinterface

// File: rtl/bus_word_pack.sv
// Forms one 24-bit bus word from a 5-bit meta opcode and an 18-bit payload.
module bus_word_pack
  import bus_master_pkg::*;
(
  input  logic [4:0]  meta,
  input  logic [17:0] data,
  output logic [23:0] word
);

  always_comb begin
    word                  = '0;
    word[META_HI:META_LO] = meta;
    word[DATA_HI:DATA_LO] = data;
  end

endmodule

// File: rtl/bus_master.sv
// Serialises one convolution job (descriptor + image/filter data stream) onto the accelerator
// master bus. Define BUS_MASTER_PREAMBLE_RST_EN to prefix every job with a PROTOCOL_RST word.
module bus_master
  import bus_master_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  bus_master_if.master bus
);

  state_t      state;
  job_desc_t   desc;
  logic [15:0] remaining;
  logic [4:0]  word_meta;
  logic [17:0] word_data;
  logic [23:0] word;
  logic        in_data_state;
  logic        take;

  assign in_data_state  = (state == ST_IMG_DATA) || (state == ST_FLT_DATA);
  assign bus.data_ready = in_data_state && (remaining != 16'd0);
  assign bus.job_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign take           = bus.data_valid && bus.data_ready;

  // Word the current state puts on the bus at the next edge; stalled data cycles stay NOOP.
  always_comb begin
    word_meta = OP_NOOP;
    word_data = '0;
    case (state)
`ifdef BUS_MASTER_PREAMBLE_RST_EN
      ST_PRE_RST: word_meta = OP_PROTOCOL_RST;
`endif
      ST_IMG_START: begin
        word_meta = OP_START_IMAGE;
        word_data = {2'b00, desc.image_offset};
      end
      ST_IMG_INFO: begin
        word_meta = OP_IMAGE_INFO;
        word_data = {1'b0, desc.image_depth, desc.image_dim};
      end
      ST_IMG_DATA, ST_FLT_DATA: begin
        if (take) begin
          word_meta = OP_DATA;
          word_data = bus.data_in;
        end
      end
      ST_FLT_START: begin
        word_meta = OP_START_FILTER;
        word_data = {2'b00, desc.filter_offset};
      end
      ST_FLT_INFO: begin
        word_meta = OP_FILTER_INFO;
        word_data = {desc.filter_halfsize, desc.filter_stride, desc.filter_length};
      end
      ST_FLT_BIAS: begin
        word_meta = OP_FILTER_BIAS;
        word_data = desc.filter_bias;
      end
      ST_SET_OUT: begin
        word_meta = OP_SET_OUTPUT;
        word_data = {2'b00, desc.output_offset};
      end
      ST_RUN: word_meta = OP_RUN_ACCEL;
      default: ;
    endcase
  end

  bus_word_pack u_pack (
    .meta (word_meta),
    .data (word_data),
    .word (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      desc           <= '0;
      remaining      <= '0;
      bus.master_bus <= '0;
      bus.done       <= 1'b0;
    end else begin
      bus.master_bus <= word;
      bus.done       <= (state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (bus.job_valid) begin
            desc.image_offset    <= bus.image_offset;
            desc.image_dim       <= bus.image_dim;
            desc.image_depth     <= bus.image_depth;
            desc.image_words     <= bus.image_words;
            desc.filter_offset   <= bus.filter_offset;
            desc.filter_halfsize <= bus.filter_halfsize;
            desc.filter_stride   <= bus.filter_stride;
            desc.filter_length   <= bus.filter_length;
            desc.filter_bias     <= bus.filter_bias;
            desc.output_offset   <= bus.output_offset;
`ifdef BUS_MASTER_PREAMBLE_RST_EN
            state <= ST_PRE_RST;
`else
            state <= ST_IMG_START;
`endif
          end
        end
`ifdef BUS_MASTER_PREAMBLE_RST_EN
        ST_PRE_RST:   state <= ST_IMG_START;
`endif
        ST_IMG_START: state <= ST_IMG_INFO;
        ST_IMG_INFO: begin
          if (desc.image_words == 16'd0) begin
            state <= ST_FLT_START;
          end else begin
            state     <= ST_IMG_DATA;
            remaining <= desc.image_words;
          end
        end
        ST_IMG_DATA: begin
          if (take) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= ST_FLT_START;
          end
        end
        ST_FLT_START: state <= ST_FLT_INFO;
        ST_FLT_INFO:  state <= ST_FLT_BIAS;
        ST_FLT_BIAS: begin
          if (desc.filter_length == 13'd0) begin
            state <= ST_SET_OUT;
          end else begin
            state     <= ST_FLT_DATA;
            remaining <= {3'b000, desc.filter_length};
          end
        end
        ST_FLT_DATA: begin
          if (take) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= ST_SET_OUT;
          end
        end
        ST_SET_OUT: state <= ST_RUN;
        ST_RUN:     state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: per-cycle bus traces checked against hand-built word lists.
module tb_bus_master;

`ifdef BUS_MASTER_PREAMBLE_RST_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   ready_seen;

  logic [23:0] trace[$];
  logic        done_trace[$];
  logic [23:0] exp_q[$];
  logic [17:0] stream[$];

  bus_master_if m ();

  bus_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_job(input logic [15:0] img_words, input logic [12:0] flt_len);
    m.image_offset    = 16'h0100;
    m.image_dim       = 8'd4;
    m.image_depth     = 9'd1;
    m.image_words     = img_words;
    m.filter_offset   = 16'h0400;
    m.filter_halfsize = 2'd1;
    m.filter_stride   = 3'd1;
    m.filter_length   = flt_len;
    m.filter_bias     = 18'd5;
    m.output_offset   = 16'h0800;
    m.job_valid       = 1'b1;
  endtask

  // kind 0: normal job, 1: three NOOPs after first image word, 2: zero counts
  task automatic push_job_words(input int kind);
    if (PRE == 1) exp_q.push_back(24'h7C0000);
    exp_q.push_back(24'h040100);
    exp_q.push_back(24'h180104);
    if (kind != 2) begin
      exp_q.push_back(24'h1C0011);
      if (kind == 1) begin
        exp_q.push_back(24'h0);
        exp_q.push_back(24'h0);
        exp_q.push_back(24'h0);
      end
      exp_q.push_back(24'h1C0022);
    end
    exp_q.push_back(24'h080400);
    exp_q.push_back((kind == 2) ? 24'h112000 : 24'h112001);
    exp_q.push_back(24'h140005);
    if (kind != 2) exp_q.push_back(24'h1C0033);
    exp_q.push_back(24'h0C0800);
    exp_q.push_back(24'h200000);
  endtask

  task automatic run_capture(input int ncycles, input int stall_start, input int stall_len,
                             input bit hold_valid);
    int idx;
    idx = 0;
    trace.delete();
    done_trace.delete();
    ready_seen = 0;
    for (int c = 0; c < ncycles; c++) begin
      m.data_valid = (idx < stream.size()) && !(c >= stall_start && c < stall_start + stall_len);
      m.data_in    = (idx < stream.size()) ? stream[idx] : 18'h0;
      if (c == 1 && !hold_valid) m.job_valid = 1'b0;
      @(negedge clk);
      trace.push_back(m.master_bus);
      done_trace.push_back(m.done);
      if (m.data_ready) ready_seen++;
      if (m.data_ready && m.data_valid) idx++;
      @(posedge clk);
      #1;
    end
    m.data_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    m.job_valid  = 1'b0;
    m.data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors += 5;
    if (m.master_bus !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_bus: got %h expected 000000", m.master_bus); end
    if (m.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", m.busy); end
    if (m.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", m.done); end
    if (m.job_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_job_ready: got %b expected 1", m.job_ready); end
    if (m.data_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_ready: got %b expected 0", m.data_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (m.master_bus !== 24'h0) begin miscompares++; $display("[TB] FAIL idle_bus: got %h expected 000000", m.master_bus); end
  endtask

  task automatic test_basic_job();
    stream = {18'h11, 18'h22, 18'h33};
    exp_q = {24'h0, 24'h0};
    push_job_words(0);
    exp_q.push_back(24'h0);
    set_job(16'd2, 13'd1);
    run_capture(exp_q.size(), 1000, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors += 2;
      if (trace[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL basic_bus[%0d]: got %h expected %h", i, trace[i], exp_q[i]);
      end
      if (done_trace[i] !== (exp_q[i] == 24'h200000)) begin
        miscompares++;
        $display("[TB] FAIL basic_done[%0d]: got %b expected %b", i, done_trace[i], exp_q[i] == 24'h200000);
      end
    end
    vectors += 2;
    if (m.job_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_end_ready: got %b expected 1", m.job_ready); end
    if (m.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_end_busy: got %b expected 0", m.busy); end
  endtask

  task automatic test_stall();
    stream = {18'h11, 18'h22, 18'h33};
    exp_q = {24'h0, 24'h0};
    push_job_words(1);
    exp_q.push_back(24'h0);
    set_job(16'd2, 13'd1);
    run_capture(exp_q.size(), 4 + PRE, 3, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (trace[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_bus[%0d]: got %h expected %h", i, trace[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_counts();
    stream = {};
    exp_q = {24'h0, 24'h0};
    push_job_words(2);
    exp_q.push_back(24'h0);
    set_job(16'd0, 13'd0);
    run_capture(exp_q.size(), 1000, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors += 2;
      if (trace[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL zero_bus[%0d]: got %h expected %h", i, trace[i], exp_q[i]);
      end
      if (done_trace[i] !== (exp_q[i] == 24'h200000)) begin
        miscompares++;
        $display("[TB] FAIL zero_done[%0d]: got %b expected %b", i, done_trace[i], exp_q[i] == 24'h200000);
      end
    end
    vectors++;
    if (ready_seen !== 0) begin miscompares++; $display("[TB] FAIL zero_data_ready: got %0d ready cycles expected 0", ready_seen); end
  endtask

  task automatic test_async_reset();
    stream = {18'h11, 18'h22, 18'h33};
    set_job(16'd2, 13'd1);
    run_capture(4 + PRE, 1000, 0, 1'b0);
    vectors++;
    if (m.master_bus !== 24'h1C0011) begin miscompares++; $display("[TB] FAIL arst_pre_bus: got %h expected 1c0011", m.master_bus); end
    m.data_valid = 1'b1;
    m.data_in    = 18'h22;
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (m.master_bus !== 24'h0) begin miscompares++; $display("[TB] FAIL arst_bus: got %h expected 000000", m.master_bus); end
    if (m.job_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_job_ready: got %b expected 1", m.job_ready); end
    if (m.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_busy: got %b expected 0", m.busy); end
    if (m.data_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_data_ready: got %b expected 0", m.data_ready); end
    #2;
    rst_n = 1'b1;
    m.data_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q = {24'h0, 24'h0};
    push_job_words(0);
    exp_q.push_back(24'h0);
    set_job(16'd2, 13'd1);
    run_capture(exp_q.size(), 1000, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (trace[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL arst_restart_bus[%0d]: got %h expected %h", i, trace[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stream = {18'h11, 18'h22, 18'h33, 18'h11, 18'h22, 18'h33};
    exp_q = {24'h0, 24'h0};
    push_job_words(0);
    exp_q.push_back(24'h0);
    push_job_words(0);
    set_job(16'd2, 13'd1);
    run_capture(exp_q.size(), 1000, 0, 1'b1);
    m.job_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors += 2;
      if (trace[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_bus[%0d]: got %h expected %h", i, trace[i], exp_q[i]);
      end
      if (done_trace[i] !== (exp_q[i] == 24'h200000)) begin
        miscompares++;
        $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", i, done_trace[i], exp_q[i] == 24'h200000);
      end
    end
    pulse_reset();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    m.job_valid  = 1'b0;
    m.data_valid = 1'b0;
    m.data_in    = '0;
    set_job(16'd0, 13'd0);
    m.job_valid  = 1'b0;
    test_reset();
    test_basic_job();
    test_stall();
    test_zero_counts();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
